// File: rtl/line_pkg.sv
// Shared definitions for the Bresenham line stepper: FSM encoding,
// default coordinate width and small signed helpers used during setup.
package line_pkg;

  localparam int COORD_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Magnitude of a signed value; callers keep inputs well inside 32 bits.
  function automatic logic signed [31:0] abs_s32(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

  // Step direction for one axis given (end - start): negative unless the
  // end lies strictly ahead. A zero delta never steps, so its sign is moot.
  function automatic logic step_neg(input logic signed [31:0] v);
    return (v <= 0);
  endfunction

endpackage

// File: rtl/line_err_step.sv
// One Bresenham error update: decides which axes advance this pixel and
// produces the next error term. Purely combinational.
module line_err_step #(
  parameter int ERR_W = 14
) (
  input  logic signed [ERR_W-1:0] err_i,
  input  logic signed [ERR_W-1:0] dx_i,
  input  logic signed [ERR_W-1:0] dy_i,
  output logic                    step_x_o,
  output logic                    step_y_o,
  output logic signed [ERR_W-1:0] err_o
);

  // 2*err needs one extra bit so the doubling can never overflow.
  logic signed [ERR_W:0]   e2;
  logic signed [ERR_W:0]   dx_ext;
  logic signed [ERR_W:0]   dy_ext;
  logic signed [ERR_W-1:0] dlt_x;
  logic signed [ERR_W-1:0] dlt_y;

  assign e2     = {err_i, 1'b0};
  assign dx_ext = {dx_i[ERR_W-1], dx_i};
  assign dy_ext = {dy_i[ERR_W-1], dy_i};

  // Both axis decisions use the pre-update error; deltas are summed.
  always_comb begin
    step_x_o = (e2 >= dy_ext);
    step_y_o = (e2 <= dx_ext);
    dlt_x    = '0;
    dlt_y    = '0;
    if (step_x_o) dlt_x = dy_i;
    if (step_y_o) dlt_y = dx_i;
    err_o    = err_i + dlt_x + dlt_y;
  end

endmodule

// File: rtl/line_stepper.sv
// All-octant Bresenham rasteriser. Latches an endpoint pair on start,
// spends one cycle deriving deltas, then streams one pixel per accepted
// valid/ready transfer and pulses done once the end point is taken.
module line_stepper
  import line_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               done
);

  state_e state_q, state_d;

  logic [COORD_W-1:0]      cur_x_q, cur_y_q;
  logic [COORD_W-1:0]      end_x_q, end_y_q;
  logic signed [ERR_W-1:0] dx_q, dy_q, err_q;
  logic                    sx_neg_q, sy_neg_q;

  logic                    at_end;
  logic                    xfer;
  logic                    step_x, step_y;
  logic signed [ERR_W-1:0] err_nxt;
  logic signed [ERR_W-1:0] diff_x, diff_y;
  logic signed [ERR_W-1:0] abs_x, abs_y;

  assign at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign xfer   = (state_q == RUN) && pix_ready;

  // Setup arithmetic works on the latched endpoints (cur still holds the start).
  assign diff_x = ERR_W'(end_x_q) - ERR_W'(cur_x_q);
  assign diff_y = ERR_W'(end_y_q) - ERR_W'(cur_y_q);
  assign abs_x  = ERR_W'(abs_s32(32'(diff_x)));
  assign abs_y  = ERR_W'(abs_s32(32'(diff_y)));

  line_err_step #(
    .ERR_W(ERR_W)
  ) u_err_step (
    .err_i   (err_q),
    .dx_i    (dx_q),
    .dy_i    (dy_q),
    .step_x_o(step_x),
    .step_y_o(step_y),
    .err_o   (err_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: SETUP and DONE last one cycle; RUN leaves once the end point is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = RUN;
      RUN:     if (xfer && at_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything except the coordinates comes straight from state.
  always_comb begin
    busy      = 1'b0;
    pix_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      SETUP:   busy = 1'b1;
      RUN: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    pix_last = (state_q == RUN) && at_end;
  end

  assign pix_x = cur_x_q;
  assign pix_y = cur_y_q;

  // Datapath: latch endpoints, derive deltas, then advance the cursor on each non-final transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_x_q <= x0;
            cur_y_q <= y0;
            end_x_q <= x1;
            end_y_q <= y1;
          end
        end
        SETUP: begin
          dx_q     <= abs_x;
          dy_q     <= -abs_y;
          err_q    <= abs_x - abs_y;
          sx_neg_q <= step_neg(32'(diff_x));
          sy_neg_q <= step_neg(32'(diff_y));
        end
        RUN: begin
          if (xfer && !at_end) begin
            if (step_x) cur_x_q <= sx_neg_q ? cur_x_q - COORD_W'(1) : cur_x_q + COORD_W'(1);
            if (step_y) cur_y_q <= sy_neg_q ? cur_y_q - COORD_W'(1) : cur_y_q + COORD_W'(1);
            err_q <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_stepper.sv
// Directed bench for line_stepper: hand-derived pixel sequences checked
// pixel by pixel, plus backpressure, ignored start and mid-line reset.
module tb_line_stepper;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          busy, pix_valid, pix_ready, pix_last, done;
  logic [CW-1:0] pix_x, pix_y;

  int n_cmp = 0;
  int n_err = 0;
  int qx[$];
  int qy[$];

  line_stepper #(.COORD_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .busy     (busy),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_last (pix_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_last"},  32'(pix_last),  0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_x"},     32'(pix_x),     0);
    chk({tag, "_y"},     32'(pix_y),     0);
  endtask

  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("setup_busy",  32'(busy),      1);
    chk("setup_valid", 32'(pix_valid), 0);
    tick();
  endtask

  // Walk the expected pixel queue; rnd throttles pix_ready, poke fires a stray start mid-line.
  task automatic run_line(input bit rnd, input bit poke);
    int   i     = 0;
    int   stall = 0;
    int   guard = 0;
    logic r;
    while (i < qx.size() && guard < 20000) begin
      guard++;
      chk("pix_valid", 32'(pix_valid), 1);
      chk("pix_x",     32'(pix_x),     qx[i]);
      chk("pix_y",     32'(pix_y),     qy[i]);
      chk("pix_last",  32'(pix_last),  32'(i == qx.size() - 1));
      if (rnd) begin
        r     = (stall >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        stall = r ? 0 : stall + 1;
      end else begin
        r = 1'b1;
      end
      pix_ready = r;
      if (poke && i == 1) begin
        start = 1'b1;
        x0 = 12'd100; y0 = 12'd100; x1 = 12'd200; y1 = 12'd50;
      end
      tick();
      start = 1'b0;
      if (r) i++;
    end
    if (guard >= 20000) chk("pixel_timeout", 32'(guard), 0);
    pix_ready = 1'b1;
    chk("done_pulse", 32'(done),      1);
    chk("done_valid", 32'(pix_valid), 0);
    chk("done_busy",  32'(busy),      1);
    tick();
    chk("post_done",  32'(done),      0);
    chk("post_busy",  32'(busy),      0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #3;
    chk_reset_vals("rst_async");
    tick();
    chk_reset_vals("rst_held");
    reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Horizontal line, with a stray start while busy.
    pix_ready = 1'b1;
    qx = '{0, 1, 2, 3};
    qy = '{0, 0, 0, 0};
    start_line(0, 0, 3, 0);
    run_line(1'b0, 1'b1);

    // Shallow first-octant line.
    qx = '{0, 1, 2, 3, 4, 5};
    qy = '{0, 0, 1, 1, 2, 2};
    start_line(0, 0, 5, 2);
    run_line(1'b0, 1'b0);

    // Steep line with both directions negative.
    qx = '{1, 1, 0, 0, 0};
    qy = '{4, 3, 2, 1, 0};
    start_line(1, 4, 0, 0);
    run_line(1'b0, 1'b0);

    // Degenerate single-pixel line.
    qx = '{7};
    qy = '{7};
    start_line(7, 7, 7, 7);
    run_line(1'b0, 1'b0);

    // Same shallow line under random backpressure.
    qx = '{0, 1, 2, 3, 4, 5};
    qy = '{0, 0, 1, 1, 2, 2};
    start_line(0, 0, 5, 2);
    run_line(1'b1, 1'b0);

    // Full-range diagonal.
    qx.delete();
    qy.delete();
    for (int k = 0; k < 4096; k++) begin
      qx.push_back(k);
      qy.push_back(k);
    end
    start_line(0, 0, 4095, 4095);
    run_line(1'b0, 1'b0);

    // Reset while the third pixel is on offer.
    pix_ready = 1'b1;
    start_line(0, 0, 5, 2);
    tick();
    tick();
    chk("rst_mid_px", 32'(pix_x), 2);
    chk("rst_mid_py", 32'(pix_y), 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    chk("rst_mid_nodone", 32'(done), 0);
    chk("rst_mid_idle",   32'(busy), 0);
    reset = 1'b1;
    tick();
    chk("rst_release_done", 32'(done), 0);

    // Next line after reset, under backpressure.
    qx = '{1, 1, 0, 0, 0};
    qy = '{4, 3, 2, 1, 0};
    start_line(1, 4, 0, 0);
    run_line(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_stepper.md
Name: line_stepper

Overview:
- Parametrised Bresenham line rasteriser: successor to the single-octant error controller FSM, with the datapath folded in.
- Covers all eight octants and degenerate lines, with configurable coordinate width.
- Emits one pixel coordinate per accepted valid/ready transfer.
- Sits between the command decoder (endpoint pairs in) and the pixel writer / framebuffer address generator (pixel stream out).

Parameters:
- COORD_W, 12, unsigned coordinate width in bits.
- ERR_W, COORD_W+2, signed width of the error accumulator.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately, deasserted synchronously by the reset tree
- start  in  1  one-cycle request to draw; sampled only in IDLE
- x0, y0  in  COORD_W each  start point, sampled with start
- x1, y1  in  COORD_W each  end point, sampled with start
- busy  out  1  high from the cycle after accepted start until DONE exits
- pix_valid  out  1  current pixel coordinate is valid
- pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready
- pix_x, pix_y  out  COORD_W each  current pixel coordinate
- pix_last  out  1  current pixel is the end point; qualified by pix_valid
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset values: state=IDLE, busy=0, pix_valid=0, pix_last=0, done=0, pix_x=pix_y=0, err=0.
- FSM states:
  - IDLE: start=1 latches x0,y0,x1,y1 and goes to SETUP; start=0 stays.
  - SETUP (1 cycle): computes dx=|x1-x0|, dy=-|y1-y0|, sx=+1 if x0<x1 else -1, sy likewise, err=dx+dy, cur=(x0,y0); goes to RUN.
  - RUN: pix_valid=1 with cur.
    - No transfer: hold all outputs and registers stable.
    - Transfer, cur==(x1,y1): go to DONE.
    - Transfer otherwise, with e2=2*err sign-extended to ERR_W+1:
      - if e2>=dy: err+=dy, x+=sx
      - if e2<=dx: err+=dx, y+=sy
      - both updates may apply in the same cycle; err uses the summed delta.
  - DONE (1 cycle): done=1, busy=1, pix_valid=0; goes to IDLE.
- Latency: first pix_valid 2 cycles after start is sampled. With pix_ready held high, one pixel per cycle.
- Pixel count is max(|x1-x0|,|y1-y0|)+1.
- pix_last is combinational from the cur==end compare, registered inputs only.
- Arithmetic: all deltas and err are signed two's complement at ERR_W bits. Coordinates stay unsigned COORD_W and never leave [min(x0,x1),max(x0,x1)] (likewise y), so no wrap.
- Degenerate line (x0==x1, y0==y1): exactly one pixel with pix_last=1.
- Pure horizontal and pure vertical lines need no special path; the arithmetic handles them.
- start outside IDLE is ignored; no queueing.
- Reset asserted mid-line: returns to IDLE immediately. No done pulse, pix_valid drops asynchronously, the partial line is discarded.
- pix_valid never drops without a transfer, except on reset.

Decomposition:
- Shared package line_pkg: state encoding constants (IDLE, SETUP, RUN, DONE), COORD_W default, and a signed abs/sign helper function.
- One sub-module, line_err_step: purely combinational. Takes err, dx, dy and returns step_x, step_y and next err. It is unit-testable in isolation.
- The FSM and registers stay in the top module.

Test Plan:
- (0,0)->(3,0), pix_ready=1: pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; pix_last only on (3,0); done 1 cycle later.
- (0,0)->(5,2): exact sequence (0,0),(1,0),(2,1),(3,1),(4,2),(5,2).
- (1,4)->(0,0), steep with negative sx/sy: sequence (1,4),(1,3),(0,2),(0,1),(0,0).
- (7,7)->(7,7): single pixel with pix_last=1, then done. Separately, (0,0)->(4095,4095) at COORD_W=12: 4096 diagonal pixels, no overflow.
- Backpressure: random pix_ready on (0,0)->(5,2): same sequence; pix_x/pix_y/pix_last held stable while valid && !ready.
- Protocol and reset:
  - start pulsed while busy: ignored.
  - reset low during the 3rd pixel: all outputs at reset values within the same cycle, no done.
  - next start after reset draws the correct line.
